// File: rtl/hub75_bcm_scan_driver.sv
// HUB75 panel scan engine: walks row pairs and BCM bit planes, fetching pixels
// from a synchronous frame-buffer read port and driving the panel pins.
module hub75_bcm_scan_driver #(
  parameter int unsigned NUM_COLS    = 64,
  parameter int unsigned SCAN_RATE   = 32,
  parameter int unsigned COLOR_DEPTH = 3,
  parameter int unsigned BCM_BASE    = 8,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic                                          enable_in,
  output logic [$clog2(SCAN_RATE)+$clog2(NUM_COLS)-1:0] pix_addr_out,
  input  logic [6*COLOR_DEPTH-1:0]                      pix_data_in,
  output logic [2:0]                                    rgb0,
  output logic [2:0]                                    rgb1,
  output logic [$clog2(SCAN_RATE)-1:0]                  row_addr,
  output logic                                          led_clk,
  output logic                                          led_latch,
  output logic                                          led_output_enable,
  output logic                                          frame_done
);

  localparam int unsigned ROW_W    = $clog2(SCAN_RATE);
  localparam int unsigned COL_W    = $clog2(NUM_COLS);
  localparam int unsigned PLANE_W  = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
  localparam int unsigned DISP_MAX = BCM_BASE << (COLOR_DEPTH - 1);
  localparam int unsigned CNT_W    = $clog2(DISP_MAX + 1);

  // The address is held for both phases of a column, so data for column c is
  // valid at its phase A for either read latency without extra alignment.
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_rd_latency
    $error("hub75_bcm_scan_driver: RD_LATENCY must be 1 or 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFETCH = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_LATCH    = 3'd3,
    ST_DISPLAY  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [COL_W-1:0]   col, col_n;
  logic               phase, phase_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [PLANE_W-1:0] plane, plane_n;
  logic [ROW_W-1:0]   row, row_n;
  logic               disp_last;
  logic               frame_wrap;

  logic [COL_W+ROW_W-1:0] pix_addr_d;
  logic [2:0]             rgb0_d, rgb1_d;
  logic [ROW_W-1:0]       row_addr_d;
  logic                   led_clk_d, led_latch_d, oe_d, frame_done_d;

  // State, counters and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= ST_IDLE;
      col               <= '0;
      phase             <= 1'b0;
      cnt               <= '0;
      plane             <= '0;
      row               <= '0;
      pix_addr_out      <= '0;
      rgb0              <= '0;
      rgb1              <= '0;
      row_addr          <= '0;
      led_clk           <= 1'b0;
      led_latch         <= 1'b0;
      led_output_enable <= 1'b1;
      frame_done        <= 1'b0;
    end else begin
      state             <= state_n;
      col               <= col_n;
      phase             <= phase_n;
      cnt               <= cnt_n;
      plane             <= plane_n;
      row               <= row_n;
      pix_addr_out      <= pix_addr_d;
      rgb0              <= rgb0_d;
      rgb1              <= rgb1_d;
      row_addr          <= row_addr_d;
      led_clk           <= led_clk_d;
      led_latch         <= led_latch_d;
      led_output_enable <= oe_d;
      frame_done        <= frame_done_d;
    end
  end

  // Next state and scan counters.
  always_comb begin
    state_n    = state;
    col_n      = col;
    phase_n    = phase;
    cnt_n      = cnt;
    plane_n    = plane;
    row_n      = row;
    frame_wrap = 1'b0;
    disp_last  = (cnt == CNT_W'((BCM_BASE << plane) - 1));
    case (state)
      ST_IDLE: begin
        if (enable_in) begin
          state_n = ST_PREFETCH;
          cnt_n   = '0;
        end
      end
      ST_PREFETCH: begin
        if (cnt == CNT_W'(1)) begin
          state_n = ST_SHIFT;
          col_n   = '0;
          phase_n = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        phase_n = ~phase;
        if (phase) begin
          if (col == COL_W'(NUM_COLS - 1)) state_n = ST_LATCH;
          else                             col_n   = col + COL_W'(1);
        end
      end
      ST_LATCH: begin
        state_n = ST_DISPLAY;
        cnt_n   = '0;
      end
      ST_DISPLAY: begin
        if (disp_last) begin
          cnt_n = '0;
          if (plane == PLANE_W'(COLOR_DEPTH - 1)) begin
            plane_n = '0;
            if (row == ROW_W'(SCAN_RATE - 1)) begin
              row_n      = '0;
              frame_wrap = 1'b1;
            end else begin
              row_n = row + ROW_W'(1);
            end
          end else begin
            plane_n = plane + PLANE_W'(1);
          end
          state_n = enable_in ? ST_PREFETCH : ST_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output values; the read address tracks the upcoming state so it leads the data.
  always_comb begin
    logic [COLOR_DEPTH-1:0] top_ch;
    logic [COLOR_DEPTH-1:0] bot_ch;
    logic [2:0]             sample_top;
    logic [2:0]             sample_bot;
    sample_top   = '0;
    sample_bot   = '0;
    rgb0_d       = rgb0;
    rgb1_d       = rgb1;
    row_addr_d   = row_addr;
    pix_addr_d   = pix_addr_out;
    led_clk_d    = 1'b0;
    led_latch_d  = 1'b0;
    oe_d         = 1'b1;
    frame_done_d = frame_wrap;
    for (int ch = 0; ch < 3; ch++) begin
      top_ch         = pix_data_in[ch*COLOR_DEPTH +: COLOR_DEPTH];
      bot_ch         = pix_data_in[(ch+3)*COLOR_DEPTH +: COLOR_DEPTH];
      sample_top[ch] = top_ch[plane];
      sample_bot[ch] = bot_ch[plane];
    end
    case (state)
      ST_SHIFT: begin
        if (!phase) begin
          rgb0_d = sample_top;
          rgb1_d = sample_bot;
        end else begin
          led_clk_d = 1'b1;
        end
      end
      ST_LATCH: begin
        led_latch_d = 1'b1;
        row_addr_d  = row;
      end
      ST_DISPLAY: oe_d = 1'b0;
      default: ;
    endcase
    if (state_n == ST_PREFETCH)               pix_addr_d = {row_n, COL_W'(0)};
    else if (state_n == ST_SHIFT && !phase_n) pix_addr_d = {row_n, col_n + COL_W'(1)};
  end

endmodule

// File: tb/tb_hub75_bcm_scan_driver.sv
// Bench for hub75_bcm_scan_driver: small panel, registered frame-buffer model,
// event monitor and a transaction-level expectation of the scan order.
module tb_hub75_bcm_scan_driver;

  localparam int ADDR_W = 3;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              enable_in = 1'b1;
  logic [ADDR_W-1:0] pix_addr_out;
  logic [11:0]       pix_data_in;
  logic [2:0]        rgb0, rgb1;
  logic [0:0]        row_addr;
  logic              led_clk, led_latch, led_output_enable, frame_done;

  hub75_bcm_scan_driver #(
    .NUM_COLS(4), .SCAN_RATE(2), .COLOR_DEPTH(2), .BCM_BASE(2), .RD_LATENCY(1)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
    .pix_addr_out(pix_addr_out), .pix_data_in(pix_data_in),
    .rgb0(rgb0), .rgb1(rgb1), .row_addr(row_addr),
    .led_clk(led_clk), .led_latch(led_latch),
    .led_output_enable(led_output_enable), .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  // Frame buffer with one cycle of read latency.
  logic [11:0] mem [8];
  always @(posedge clk_in) pix_data_in <= mem[pix_addr_out];

  typedef struct { int row; int plane; int gap; int oe; } step_t;
  step_t tab [4];

  int total = 0;
  int bad = 0;

  // Monitor state.
  logic        mon_clear = 1'b0;
  int          ncyc = 0;
  int          edges_live = 0, oe_live = 0, viol = 0, r0_cnt = 0, arow_live = 0;
  logic [23:0] shift_word = '0;
  logic        prev_clk = 1'b0;
  logic [0:0]  prev_row = 1'bx;
  int          latch_cyc[$], latch_row[$], latch_edges[$], latch_oe[$], latch_arow[$];
  logic [23:0] latch_bits[$];
  int          fd_cyc[$];

  initial forever begin
    @(negedge clk_in);
    ncyc++;
    if (mon_clear) begin
      latch_cyc.delete(); latch_row.delete(); latch_edges.delete();
      latch_oe.delete(); latch_arow.delete(); latch_bits.delete(); fd_cyc.delete();
      edges_live = 0; oe_live = 0; viol = 0; r0_cnt = 0; shift_word = '0; arow_live = 0;
    end
    if (led_clk === 1'b1 && prev_clk === 1'b0) begin
      if (edges_live == 0) arow_live = int'(pix_addr_out[ADDR_W-1]);
      if (edges_live < 4) shift_word[edges_live*6 +: 6] = {rgb1, rgb0};
      edges_live++;
    end
    if (led_output_enable === 1'b0) begin
      oe_live++;
      if (led_clk !== 1'b0 || led_latch !== 1'b0 || prev_clk !== 1'b0) viol++;
    end
    if (rgb0[0] === 1'b1) r0_cnt++;
    if (!$isunknown(prev_row) && row_addr !== prev_row && led_latch !== 1'b1) viol++;
    if (led_latch === 1'b1) begin
      latch_cyc.push_back(ncyc);
      latch_row.push_back(int'(row_addr));
      latch_edges.push_back(edges_live);
      latch_oe.push_back(oe_live);
      latch_arow.push_back(arow_live);
      latch_bits.push_back(shift_word);
      edges_live = 0; oe_live = 0; shift_word = '0;
    end
    if (frame_done === 1'b1) fd_cyc.push_back(ncyc);
    prev_clk = led_clk;
    prev_row = row_addr;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] exp_pix(int r, int p, int c);
    logic [11:0] w;
    logic [5:0]  v;
    w = mem[r*4 + c];
    for (int ch = 0; ch < 3; ch++) begin
      v[ch]     = w[ch*2 + p];
      v[3 + ch] = w[6 + ch*2 + p];
    end
    return v;
  endfunction

  function automatic logic [23:0] exp_shift(int r, int p);
    logic [23:0] s;
    for (int c = 0; c < 4; c++) s[c*6 +: 6] = exp_pix(r, p, c);
    return s;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb0"}, rgb0, 0);
    check({tag, "_rgb1"}, rgb1, 0);
    check({tag, "_row_addr"}, row_addr, 0);
    check({tag, "_pix_addr"}, pix_addr_out, 0);
    check({tag, "_led_clk"}, led_clk, 0);
    check({tag, "_led_latch"}, led_latch, 0);
    check({tag, "_oe"}, led_output_enable, 1);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic release_reset(output int base);
    rst_in    = 1'b0;
    mon_clear = 1'b1;
    base      = ncyc + 1;
    @(negedge clk_in); #1;
    mon_clear = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    @(negedge clk_in); #1;
  endtask

  task automatic wait_latches(input string name, input int n, input int budget);
    while (latch_cyc.size() < n && budget > 0) begin
      @(negedge clk_in); #1;
      budget--;
    end
    check(name, latch_cyc.size(), n);
  endtask

  task automatic analyze(input string tag, input int n_lat, input int n_fd, input int base);
    step_t e, p;
    check({tag, "_latch_count"}, latch_cyc.size(), n_lat);
    if (latch_cyc.size() > 0) check({tag, "_first_latch"}, latch_cyc[0] - base, 11);
    for (int k = 0; k < n_lat && k < latch_cyc.size(); k++) begin
      e = tab[k % 4];
      check($sformatf("%s_row_addr_%0d", tag, k), latch_row[k], e.row);
      check($sformatf("%s_edges_%0d", tag, k), latch_edges[k], 4);
      check($sformatf("%s_bits_%0d", tag, k), latch_bits[k], exp_shift(e.row, e.plane));
      check($sformatf("%s_addr_row_%0d", tag, k), latch_arow[k], e.row);
      if (k > 0) begin
        p = tab[(k - 1) % 4];
        check($sformatf("%s_gap_%0d", tag, k), latch_cyc[k] - latch_cyc[k-1], p.gap);
        check($sformatf("%s_oe_low_%0d", tag, k), latch_oe[k], p.oe);
      end else begin
        check($sformatf("%s_oe_low_%0d", tag, k), latch_oe[k], 0);
      end
    end
    check({tag, "_frame_done_count"}, fd_cyc.size(), n_fd);
    for (int i = 0; i < fd_cyc.size(); i++) begin
      if (i == 0) check({tag, "_frame_done_first"}, fd_cyc[0] - base, 56);
      else check($sformatf("%s_frame_done_gap_%0d", tag, i), fd_cyc[i] - fd_cyc[i-1], 56);
    end
    check({tag, "_violations"}, viol, 0);
  endtask

  initial begin
    int base;
    int budget;
    // Scan order for one frame: row, plane, latch-to-latch gap, OE-low cycles of that plane.
    tab[0] = '{0, 0, 13, 2};
    tab[1] = '{0, 1, 15, 4};
    tab[2] = '{1, 0, 13, 2};
    tab[3] = '{1, 1, 15, 4};

    for (int i = 0; i < 8; i++) mem[i] = 12'($urandom);
    repeat (3) @(negedge clk_in);
    #1;
    check_reset_outputs("reset");

    // Continuous scan with random pixels.
    release_reset(base);
    repeat (125) @(negedge clk_in);
    #1;
    analyze("scan", 9, 2, base);

    // Single lit pixel: top R = 2'b10 at row 1, column 2.
    for (int i = 0; i < 8; i++) mem[i] = 12'h000;
    mem[6] = 12'h002;
    pulse_reset();
    release_reset(base);
    repeat (60) @(negedge clk_in);
    #1;
    analyze("pixel", 4, 1, base);
    check("pixel_r0_cycles", r0_cnt, 2);

    // Enable drop in row 1 / plane 0 display, then resume.
    for (int i = 0; i < 8; i++) mem[i] = 12'($urandom);
    pulse_reset();
    release_reset(base);
    wait_latches("drop_wait_latch", 3, 100);
    enable_in = 1'b0;
    repeat (20) @(negedge clk_in);
    #1;
    check("drop_latch_count", latch_cyc.size(), 3);
    check("drop_oe_low", oe_live, 2);
    check("drop_oe_idle", led_output_enable, 1);
    check("drop_led_clk_idle", led_clk, 0);
    check("drop_latch_idle", led_latch, 0);
    enable_in = 1'b1;
    base = ncyc + 1;
    budget = 40;
    while (edges_live < 2 && budget > 0) begin
      @(negedge clk_in); #1;
      budget--;
    end
    check("resume_edges", edges_live, 2);
    check("resume_edge_cycle", ncyc - base, 6);
    check("resume_addr_row", arow_live, 1);
    check("resume_bits", shift_word[11:0], {exp_pix(1, 1, 1), exp_pix(1, 1, 0)});
    check("drop_violations", viol, 0);

    // Reset in the middle of the row 1 / plane 1 shift.
    pulse_reset();
    check_reset_outputs("midrst");
    release_reset(base);
    wait_latches("midrst_wait_latch", 1, 40);
    if (latch_cyc.size() > 0) begin
      check("midrst_latch_cycle", latch_cyc[0] - base, 11);
      check("midrst_row_addr", latch_row[0], 0);
      check("midrst_bits", latch_bits[0], exp_shift(0, 0));
      check("midrst_edges", latch_edges[0], 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hub75_bcm_scan_driver.md
Name: hub75_bcm_scan_driver

Overview:
- Full HUB75 panel scan engine. Walks every row pair and every bit plane of a frame, fetching pixels from an external synchronous frame-buffer read port.
- For each plane it shifts one bit per colour channel into the panel, latches, then holds output-enable for a binary-weighted time. This is bit-code modulation (BCM).
- Sits between the frame buffer / column store and the panel connector pins.

Parameters:
- NUM_COLS, 64, pixels shifted per row (power of 2, ≥4)
- SCAN_RATE, 32, row pairs per frame (power of 2, ≥2); panel height = 2*SCAN_RATE
- COLOR_DEPTH, 3, bits per colour channel = BCM bit planes
- BCM_BASE, 8, display cycles for plane 0; plane b displays BCM_BASE<<b cycles
- RD_LATENCY, 1, frame-buffer read latency in cycles; legal values 1 or 2

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- enable_in  in  1  run scanning while high
- pix_addr_out  out  $clog2(SCAN_RATE)+$clog2(NUM_COLS)  read address, {row, col}
- pix_data_in  in  6*COLOR_DEPTH  read data: [3*COLOR_DEPTH-1:0] top {B,G,R}, upper half bottom {B,G,R}; each channel is COLOR_DEPTH bits
- rgb0  out  3  top-half bits {B,G,R} of the current plane
- rgb1  out  3  bottom-half bits {B,G,R}
- row_addr  out  $clog2(SCAN_RATE)  panel A..E row select
- led_clk  out  1  registered shift clock
- led_latch  out  1  latch strobe
- led_output_enable  out  1  panel OE, active low (1 = blanked)
- frame_done  out  1  one-cycle pulse after the last plane of the last row

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE
  - rgb0 = rgb1 = 0, row_addr = 0, pix_addr_out = 0
  - led_clk = 0, led_latch = 0, frame_done = 0
  - led_output_enable = 1
  - internal row, col and plane counters = 0
- Reset is synchronous and takes effect mid-operation at any state.
- States:
  - IDLE: OE = 1. Go to PREFETCH when enable_in = 1.
  - PREFETCH (2 cycles): pix_addr_out = {row, 0}.
  - SHIFT (2*NUM_COLS cycles), two phases per column c:
    - Phase A: sample pix_data_in. Drive rgb0/rgb1 with bit `plane` of each channel. led_clk = 0. pix_addr_out = {row, c+1}, wrapping to col 0 after the last column.
    - Phase B: led_clk = 1, rgb held.
    - pix_data_in for column c is valid at column c's phase A for both RD_LATENCY values.
  - LATCH (1 cycle):
    - led_latch = 1, led_clk = 0, OE = 1.
    - row_addr <= row (the row just shifted).
  - DISPLAY (BCM_BASE<<plane cycles): OE = 0, led_latch = 0.
- OE is 1 in every state except DISPLAY. led_latch is 1 only in LATCH.
- After DISPLAY:
  - If plane < COLOR_DEPTH-1: plane++.
  - Else: plane = 0 and row++.
  - If row wraps from SCAN_RATE-1 to 0: frame_done = 1 for that cycle.
- Then go to PREFETCH if enable_in = 1, else go to IDLE with OE = 1.
- enable_in is sampled only at that plane boundary. Deasserting it never truncates a plane. Re-enable resumes at the stored row/plane.
- Cycles per plane = 2 + 2*NUM_COLS + 1 + (BCM_BASE<<plane).
- The DISPLAY counter must be wide enough for BCM_BASE<<(COLOR_DEPTH-1).

Test Plan:
All scenarios use NUM_COLS=4, SCAN_RATE=2, COLOR_DEPTH=2, BCM_BASE=2, RD_LATENCY=1, and a frame-buffer model with 1-cycle latency.
- Frame timing: enable held high from reset release. Plane 0 takes 13 cycles, plane 1 takes 15, a row takes 28. frame_done pulses exactly once per 56 cycles.
- OE weighting: count OE-low cycles per plane. Plane 0 = 2, plane 1 = 4. OE is never low while led_clk toggles or led_latch = 1.
- Pixel data: top R channel = 2'b10 at column 2 of row 1, everything else 0. rgb0[0] = 1 only during phase A/B of column 2, in the row-1/plane-1 shift. Exactly 4 led_clk rising edges per shift.
- Row select: row_addr changes only in LATCH cycles, sequence 0,0,1,1,0,… (once per plane latch). pix_addr_out row field leads row_addr by one shift.
- Enable drop: deassert enable_in mid-DISPLAY of row 1, plane 0. Driver finishes the plane, enters IDLE with OE = 1. On re-enable it starts row 1, plane 1.
- Reset mid-SHIFT: assert rst_in for 1 cycle. All outputs hit reset values on the next edge, and the next frame starts at row 0, plane 0.
